// File: rtl/capture_buffer.sv
// Ping-pong frame capture: records DEPTH samples from a trigger edge into the write
// bank while the display reads the other bank; banks swap on the display's vblank.
module capture_buffer #(
   parameter int DATA_W  = 12,
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int HOLDOFF = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              trig_active,
   input  logic              single_shot,
   input  logic              swap_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              frame_ready,
   output logic              busy,
   output logic [ADDR_W:0]   capture_count,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      ST_ARMED   = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_FULL    = 3'd2,
      ST_HOLDOFF = 3'd3,
      ST_STOPPED = 3'd4
   } state_t;

   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d, count_next;
   logic              disp_bank_q, disp_bank_d;
   logic              frame_valid_q, frame_valid_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              trig_prev_q;
   logic              trig_edge;
   logic              wr_en;

   // Both banks live in one array; the bank select is the top address bit.
   logic [DATA_W-1:0] mem [2*DEPTH];

   assign trig_edge     = trig_active & ~trig_prev_q;
   assign count_next    = (count_q == DEPTH_C) ? count_q : count_q + (ADDR_W+1)'(1);
   assign capture_count = count_q;
   assign busy          = (state_q == ST_CAPTURE);
   assign frame_ready   = (state_q == ST_FULL);
   assign state_dbg     = state_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_ARMED;
         count_q       <= '0;
         disp_bank_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         hold_q        <= '0;
         trig_prev_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         disp_bank_q   <= disp_bank_d;
         frame_valid_q <= frame_valid_d;
         hold_q        <= hold_d;
         trig_prev_q   <= trig_active;
      end
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      disp_bank_d   = disp_bank_q;
      frame_valid_d = frame_valid_q;
      hold_d        = hold_q;
      wr_en         = 1'b0;
      case (state_q)
         ST_ARMED: begin
            if (trig_edge) begin
               state_d = ST_CAPTURE;
               if (sample_valid) begin
                  wr_en   = 1'b1;
                  count_d = count_next;
                  if (count_next == DEPTH_C) state_d = ST_FULL;
               end
            end
         end
         ST_CAPTURE: begin
            // Trigger level is deliberately ignored here: frame length is fixed.
            if (sample_valid) begin
               wr_en   = 1'b1;
               count_d = count_next;
               if (count_next == DEPTH_C) state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (swap_req) begin
               disp_bank_d   = ~disp_bank_q;
               frame_valid_d = 1'b1;
               count_d       = '0;
               hold_d        = '0;
               if (single_shot)       state_d = ST_STOPPED;
               else if (HOLDOFF == 0) state_d = ST_ARMED;
               else                   state_d = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (hold_q == HOLD_LAST) state_d = ST_ARMED;
            else                     hold_d  = hold_q + HOLD_W'(1);
         end
         ST_STOPPED: begin
            if (!single_shot) state_d = ST_ARMED;
         end
         default: state_d = ST_ARMED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en && rst) mem[{~disp_bank_q, count_q[ADDR_W-1:0]}] <= sample_data;
   end

   // Registered read from the display bank; blank until a first frame has been swapped in.
   always_ff @(posedge clk) begin
      if (!rst)               rd_data <= '0;
      else if (frame_valid_q) rd_data <= mem[{disp_bank_q, rd_addr}];
      else                    rd_data <= '0;
   end

endmodule
